coin_input_conditioner: RTL and testbench
=========================================

# coin_input_conditioner

Front-end stage that turns raw, bouncy vending-machine button/coin-sensor lines into clean single-cycle `fifty`, `dollar` and `cancel` pulses. It sits directly upstream of the vending FSM and drives its like-named inputs. Each channel is synchronised, debounced, and edge-qualified. A fixed-priority arbiter guarantees at most one pulse per cycle.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive stable synchronised samples required to accept a press or a release; legal range 1..255.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `fifty_btn`  input  1  raw 50c coin sensor, active high, asynchronous to `clk`.
- `dollar_btn`  input  1  raw $1 coin sensor, active high, asynchronous.
- `cancel_btn`  input  1  raw cancel button, active high, asynchronous.
- `accept_en`  input  1  when low, debounced presses are consumed without producing a pulse.
- `fifty`  output  1  one-cycle pulse per accepted 50c event.
- `dollar`  output  1  one-cycle pulse per accepted $1 event.
- `cancel`  output  1  one-cycle pulse per accepted cancel event.
- `credit_units`  output  8  running credit in 50c units; see Configuration.

## Operation
- **Per channel**, there is a 2-flop synchroniser, then a 4-state FSM with a counter of width clog2(DEBOUNCE_CYCLES+1).
  - **IDLE**: counter = 0. A synced-high sample moves to DEB_PRESS with counter = 1.
  - **DEB_PRESS**: on a high sample, the counter increments. When the counter reaches DEBOUNCE_CYCLES, the channel raises an internal `req` for one cycle and moves to HELD. On a low sample, it returns to IDLE and clears the counter.
  - **HELD**: a low sample moves to DEB_REL with counter = 1. A high sample stays in HELD; no further `req` is raised.
  - **DEB_REL**: on a low sample, the counter increments. When it reaches DEBOUNCE_CYCLES, the channel moves to IDLE. On a high sample, it returns to HELD with no new `req`.
- **Arbiter** (all outputs registered):
  - If `accept_en` = 1, the highest-priority pending `req` (cancel > dollar > fifty) asserts its output pulse.
  - Lower-priority `req`s raised in the same cycle are dropped, not queued.
  - If `accept_en` = 0, all `req`s are dropped.
- **Outputs**: at most one of `fifty`/`dollar`/`cancel` is high in any cycle, and each pulse is exactly one cycle wide.
- **Reset**: clears the synchronisers, all FSMs to IDLE, all counters, all outputs and `credit_units`.
- **Reset mid-operation**: a press in progress is discarded. A button still high after `rst` deasserts is re-debounced from IDLE and does produce a pulse.

## Timing
- **Reset values**: `fifty` = `dollar` = `cancel` = 0 and `credit_units` = 0.
- **Latency**: if a raw line is first sampled high at edge N and stays high, its output pulse is high during cycle N+DEBOUNCE_CYCLES+2. This is 2 cycles of synchroniser, DEBOUNCE_CYCLES cycles of qualification, and 1 output register, counted inclusively from the sampling edge.
- **Minimum glitch rejected**: any high pulse shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no output.
- **Minimum repeat interval**: a new pulse on the same channel is possible no sooner than 2×DEBOUNCE_CYCLES cycles after the previous one, because a full release must first be qualified.
- `accept_en` is sampled in the same cycle `req` is raised. It has no effect on channel FSM progress.
- `credit_units` updates on the edge after the pulse cycle.

## Configuration
- **`COIN_TALLY_EN` defined**:
  - `credit_units` adds 1 on each `fifty` pulse and 2 on each `dollar` pulse, saturating at 255; it never wraps.
  - A `cancel` pulse clears it to 0.
  - Increment and clear never coincide, since the outputs are one-hot.
- **`COIN_TALLY_EN` not defined**: `credit_units` is tied to 8'd0, no tally register is built, and all other behaviour is identical.

## Test plan
- **Clean 50c**: DEBOUNCE_CYCLES = 4; `fifty_btn` high at edge 10, held 20 cycles → `fifty` high only in cycle 16; no other outputs; `credit_units` = 1 (with `COIN_TALLY_EN`).
- **Bounce**: `dollar_btn` toggles 1,0,1,1,0 over edges 0–4, then held high from edge 5 → exactly one `dollar` pulse, in cycle 11; no pulse from the bounces.
- **Simultaneous**: `fifty_btn`, `dollar_btn` and `cancel_btn` all rise at edge 0 → only `cancel` pulses, in cycle 6; `fifty` and `dollar` never pulse for this press, even while held.
- **Inhibit**: `accept_en` = 0 when `fifty` would fire; then `accept_en` = 1 while still held → no pulse. After release and a new press → pulse.
- **Saturation / clear** (`COIN_TALLY_EN`): 130 `dollar` presses → `credit_units` = 255. Then one `cancel` → 0.
- **Reset mid-operation**: `rst` = 1 for one cycle at edge 3 of a held `fifty_btn` → all outputs 0 through reset. `fifty` then pulses 6 cycles after the first post-reset sampling edge.

Source files
------------

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner
//
// Turns raw, bouncy vending-machine coin/button lines into clean one-cycle
// fifty/dollar/cancel pulses for the downstream vending FSM. Each channel is
// synchronised (2 flops), debounced by a 4-state FSM, and edge-qualified.
// A fixed-priority registered arbiter (cancel > dollar > fifty) guarantees
// at most one output pulse per cycle.
//
// Optional feature macro: COIN_TALLY_EN
//   defined     : credit_units_o tallies credit in 50c units (+1 fifty,
//                 +2 dollar, saturating at 255, cleared by cancel).
//   not defined : credit_units_o is tied to zero and no tally is built.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples needed to accept
//                    a press or a release (1..255).
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           synchronous active-high reset
//   fifty_btn_i     raw 50c sensor (asynchronous)
//   dollar_btn_i    raw $1 sensor (asynchronous)
//   cancel_btn_i    raw cancel button (asynchronous)
//   accept_en_i     when low, qualified presses are consumed without a pulse
//   fifty_o         one-cycle pulse per accepted 50c event
//   dollar_o        one-cycle pulse per accepted $1 event
//   cancel_o        one-cycle pulse per accepted cancel event
//   credit_units_o  running credit in 50c units (zero without COIN_TALLY_EN)

module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       fifty_btn_i,
    input  logic       dollar_btn_i,
    input  logic       cancel_btn_i,
    input  logic       accept_en_i,
    output logic       fifty_o,
    output logic       dollar_o,
    output logic       cancel_o,
    output logic [7:0] credit_units_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value at which the next matching sample completes qualification.
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DEB_PRESS = 2'd1,
        ST_HELD      = 2'd2,
        ST_DEB_REL   = 2'd3
    } deb_state_e;

    // Channel index: 0 = fifty, 1 = dollar, 2 = cancel (also priority order).
    logic [2:0] btn_s;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] req_s;
    logic       fifty_q;
    logic       dollar_q;
    logic       cancel_q;

    assign btn_s = {cancel_btn_i, dollar_btn_i, fifty_btn_i};

    // Two-flop synchronisers for the asynchronous raw lines.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= btn_s;
            sync2_q <= sync1_q;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        deb_state_e    state_q;
        logic [CW-1:0] cnt_q;
        logic          req_q;

        assign req_s[ch] = req_q;

        // Debounce FSM: req_q pulses once when a press has been qualified.
        // With DEBOUNCE_CYCLES == 1 the first matching sample completes
        // qualification, so the DEB_* states are skipped.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                req_q   <= 1'b0;
            end else begin
                req_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (sync2_q[ch]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q <= ST_HELD;
                                cnt_q   <= '0;
                                req_q   <= 1'b1;
                            end else begin
                                state_q <= ST_DEB_PRESS;
                                cnt_q   <= CNT_ONE;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    ST_DEB_PRESS: begin
                        if (!sync2_q[ch]) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q <= ST_HELD;
                            cnt_q   <= '0;
                            req_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    ST_HELD: begin
                        if (sync2_q[ch]) begin
                            cnt_q <= '0;
                        end else if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_DEB_REL;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    ST_DEB_REL: begin
                        if (sync2_q[ch]) begin
                            state_q <= ST_HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Registered fixed-priority arbiter; losing or inhibited requests are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifty_q  <= 1'b0;
            dollar_q <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            cancel_q <= accept_en_i & req_s[2];
            dollar_q <= accept_en_i & req_s[1] & ~req_s[2];
            fifty_q  <= accept_en_i & req_s[0] & ~req_s[1] & ~req_s[2];
        end
    end

    assign fifty_o  = fifty_q;
    assign dollar_o = dollar_q;
    assign cancel_o = cancel_q;

`ifdef COIN_TALLY_EN
    logic [7:0] credit_q;
    logic [7:0] credit_d;

    // Saturating credit tally; outputs are one-hot so at most one term applies.
    always_comb begin
        credit_d = credit_q;
        if (cancel_q) begin
            credit_d = 8'd0;
        end else if (dollar_q) begin
            credit_d = (credit_q >= 8'd254) ? 8'd255 : credit_q + 8'd2;
        end else if (fifty_q) begin
            credit_d = (credit_q == 8'd255) ? 8'd255 : credit_q + 8'd1;
        end else begin
            credit_d = credit_q;
        end
    end

    // Credit register, updated on the edge after the pulse cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_q <= 8'd0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit_units_o = credit_q;
`else
    assign credit_units_o = 8'd0;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
module tb_coin_input_conditioner;

    localparam int D = 4;
`ifdef COIN_TALLY_EN
    localparam bit TALLY = 1'b1;
`else
    localparam bit TALLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifty_btn = 1'b0;
    logic       dollar_btn = 1'b0;
    logic       cancel_btn = 1'b0;
    logic       accept_en = 1'b1;
    logic       fifty;
    logic       dollar;
    logic       cancel;
    logic [7:0] credit_units;

    int checks = 0;
    int failures = 0;

    // Reference model state (behavioural, per-edge).
    logic [2:0] m_sync1, m_sync2, m_req, m_acc, m_out;
    int         m_run [3];
    int         m_credit;

    coin_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fifty_btn_i    (fifty_btn),
        .dollar_btn_i   (dollar_btn),
        .cancel_btn_i   (cancel_btn),
        .accept_en_i    (accept_en),
        .fifty_o        (fifty),
        .dollar_o       (dollar),
        .cancel_o       (cancel),
        .credit_units_o (credit_units)
    );

    always #5 clk = ~clk;

    // Advance one edge, update the model from the spec's rules, settle 1ns.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_sync1 = 3'b000; m_sync2 = 3'b000; m_req = 3'b000;
            m_acc = 3'b000; m_out = 3'b000; m_credit = 0;
            for (int c = 0; c < 3; c++) m_run[c] = 0;
        end else begin
            if (TALLY) begin
                if (m_out[2]) m_credit = 0;
                else if (m_out[1]) m_credit = (m_credit + 2 > 255) ? 255 : m_credit + 2;
                else if (m_out[0]) m_credit = (m_credit + 1 > 255) ? 255 : m_credit + 1;
            end
            m_out = 3'b000;
            if (accept_en) begin
                if (m_req[2]) m_out = 3'b100;
                else if (m_req[1]) m_out = 3'b010;
                else if (m_req[0]) m_out = 3'b001;
            end
            for (int c = 0; c < 3; c++) begin
                m_req[c] = 1'b0;
                if (m_sync2[c] != m_acc[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_acc[c] = m_sync2[c];
                        m_run[c] = 0;
                        m_req[c] = m_sync2[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_sync2 = m_sync1;
            m_sync1 = {cancel_btn, dollar_btn, fifty_btn};
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fifty_btn = 1'b0; dollar_btn = 1'b0; cancel_btn = 1'b0; accept_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({fifty, dollar, cancel} !== 3'b000) begin
            failures++; $display("FAIL reset_outputs got=%b want=000", {fifty, dollar, cancel});
        end
        checks++;
        if (credit_units !== 8'd0) begin
            failures++; $display("FAIL reset_credit got=%0d want=0", credit_units);
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_fifty();
        int first = -1; int nf = 0; int nother = 0;
        do_reset();
        fifty_btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 21) fifty_btn = 1'b0;
            tick();
            if (fifty) begin nf++; if (first < 0) first = i; end
            if (dollar || cancel) nother++;
        end
        checks++;
        if (first !== D + 3) begin
            failures++; $display("FAIL clean_latency got_tick=%0d want_tick=%0d", first, D + 3);
        end
        checks++;
        if (nf !== 1 || nother !== 0) begin
            failures++; $display("FAIL clean_count fifty=%0d other=%0d want 1/0", nf, nother);
        end
        checks++;
        if (credit_units !== (TALLY ? 8'd1 : 8'd0)) begin
            failures++; $display("FAIL clean_credit got=%0d want=%0d", credit_units, TALLY ? 1 : 0);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b01101; // edges 0..4 = 1,0,1,1,0 (LSB first)
        int first = -1; int nd = 0;
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            dollar_btn = (i <= 5) ? pat[i-1] : 1'b1;
            tick();
            if (dollar) begin nd++; if (first < 0) first = i; end
        end
        checks++;
        if (first !== 12 || nd !== 1) begin
            failures++; $display("FAIL bounce first_tick=%0d count=%0d want 12/1", first, nd);
        end
    endtask

    task automatic test_simultaneous();
        int first = -1; int nc = 0; int nfd = 0;
        do_reset();
        fifty_btn = 1'b1; dollar_btn = 1'b1; cancel_btn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (cancel) begin nc++; if (first < 0) first = i; end
            if (fifty || dollar) nfd++;
        end
        checks++;
        if (first !== 7 || nc !== 1) begin
            failures++; $display("FAIL simul_cancel first_tick=%0d count=%0d want 7/1", first, nc);
        end
        checks++;
        if (nfd !== 0) begin
            failures++; $display("FAIL simul_lower got=%0d want=0", nfd);
        end
    endtask

    task automatic test_inhibit();
        int n1 = 0; int n2 = 0;
        do_reset();
        accept_en = 1'b0;
        fifty_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 9) accept_en = 1'b1;
            tick();
            if (fifty) n1++;
        end
        checks++;
        if (n1 !== 0) begin
            failures++; $display("FAIL inhibit_drop got=%0d want=0", n1);
        end
        fifty_btn = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        fifty_btn = 1'b1;
        for (int i = 0; i < 12; i++) begin tick(); if (fifty) n2++; end
        fifty_btn = 1'b0;
        checks++;
        if (n2 !== 1) begin
            failures++; $display("FAIL inhibit_repress got=%0d want=1", n2);
        end
    endtask

    task automatic dollar_press();
        dollar_btn = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        dollar_btn = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < 127; p++) dollar_press();
        checks++;
        if (credit_units !== (TALLY ? 8'd254 : 8'd0)) begin
            failures++; $display("FAIL sat_254 got=%0d want=%0d", credit_units, TALLY ? 254 : 0);
        end
        for (int p = 0; p < 3; p++) dollar_press();
        checks++;
        if (credit_units !== (TALLY ? 8'd255 : 8'd0)) begin
            failures++; $display("FAIL sat_255 got=%0d want=%0d", credit_units, TALLY ? 255 : 0);
        end
        cancel_btn = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        cancel_btn = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (credit_units !== 8'd0) begin
            failures++; $display("FAIL sat_clear got=%0d want=0", credit_units);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1; int early = 0;
        do_reset();
        fifty_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            rst = (i == 4);
            tick();
            if (i <= 10 && (fifty || dollar || cancel)) early++;
            if (fifty && first < 0) first = i;
        end
        rst = 1'b0;
        fifty_btn = 1'b0;
        checks++;
        if (early !== 0) begin
            failures++; $display("FAIL rstmid_quiet got=%0d want=0", early);
        end
        checks++;
        if (first !== 11) begin
            failures++; $display("FAIL rstmid_pulse got_tick=%0d want_tick=11", first);
        end
    endtask

    task automatic test_random();
        logic [2:0] lvl = 3'b000;
        int rem [3];
        for (int c = 0; c < 3; c++) rem[c] = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 3; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    lvl[c] = ~lvl[c];
                    rem[c] = int'($urandom_range(1, 2 * D + 3));
                end
            end
            {cancel_btn, dollar_btn, fifty_btn} = lvl;
            if ($urandom_range(0, 15) == 0) accept_en = ~accept_en;
            rst = ($urandom_range(0, 249) == 0);
            tick();
            checks++;
            if ({cancel, dollar, fifty} !== m_out || credit_units !== m_credit[7:0]) begin
                failures++;
                $display("FAIL random_cycle%0d got cdf=%b credit=%0d want cdf=%b credit=%0d",
                         i, {cancel, dollar, fifty}, credit_units, m_out, m_credit);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_fifty();
        test_bounce();
        test_simultaneous();
        test_inhibit();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
